if_stage: RTL

- Instruction-fetch stage of the 16-bit pipelined CPU.
- Owns the program counter and drives the instruction memory address.
- Registers the fetched 16-bit word with a valid flag for the decode stage.
- Handles decode stall, branch redirect/flush from execute, and a HALT/restart state machine.

---
 rtl/if_stage_if.sv | 27 ++
 rtl/if_stage.sv | 110 +++++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// Fetch-stage bus: control from decode/execute, instruction memory port, and decode outputs.
// master = fetch stage, slave = the surrounding pipeline/memory.
interface if_stage_if #(
   parameter int ADDR_W = 8
);
   logic              start;
   logic              stall;
   logic              branch_taken;
   logic [ADDR_W-1:0] branch_target;
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0]       imem_data;
   logic [15:0]       instruction;
   logic              instr_valid;
   logic [ADDR_W-1:0] pc_out;
   logic              halted;
   logic [15:0]       fetch_count;

   modport master (
      input  start, stall, branch_taken, branch_target, imem_data,
      output imem_addr, instruction, instr_valid, pc_out, halted, fetch_count
   );

   modport slave (
      output start, stall, branch_taken, branch_target, imem_data,
      input  imem_addr, instruction, instr_valid, pc_out, halted, fetch_count
   );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, instruction register, stall/redirect handling and IDLE/RUN/HALT control.
// Define IF_PERF_CNT_EN to build the fetched-instruction counter; otherwise fetch_count is tied to zero.
module if_stage #(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [4:0]        HALT_OP  = 5'b00001
) (
   input logic         clock,
   input logic         reset,
   if_stage_if.master  bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc_out_q, pc_out_d;
   logic [15:0]       instr_q, instr_d;
   logic              valid_q, valid_d;
   logic              halted_q, halted_d;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      pc_out_d = pc_out_q;
      instr_d  = instr_q;
      valid_d  = valid_q;
      unique case (state_q)
         S_IDLE: begin
            instr_d = 16'h0000;
            valid_d = 1'b0;
            if (bus.start) state_d = S_RUN;
         end
         S_RUN: begin
            // A redirect wins over a stall: the decode word belongs to the wrong path anyway.
            if (bus.branch_taken) begin
               pc_d    = bus.branch_target;
               instr_d = 16'h0000;
               valid_d = 1'b0;
            end else if (!bus.stall) begin
               instr_d  = bus.imem_data;
               valid_d  = 1'b1;
               pc_out_d = pc_q;
               pc_d     = pc_q + ADDR_W'(1);
               if (bus.imem_data[15:11] == HALT_OP) state_d = S_HALT;
            end
         end
         S_HALT: begin
            if (bus.branch_taken) begin
               pc_d    = bus.branch_target;
               instr_d = 16'h0000;
               valid_d = 1'b0;
               state_d = S_RUN;
            end else begin
               // The HALT word is held for decode until it is consumed, then replaced by a bubble.
               if (!bus.stall) begin
                  instr_d = 16'h0000;
                  valid_d = 1'b0;
               end
               if (bus.start) state_d = S_RUN;
            end
         end
         default: state_d = S_IDLE;
      endcase
      halted_d = (state_d == S_HALT);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         pc_out_q <= '0;
         instr_q  <= 16'h0000;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         pc_out_q <= pc_out_d;
         instr_q  <= instr_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [15:0] fetch_cnt_q, fetch_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      if (state_q == S_RUN && !bus.branch_taken && !bus.stall) fetch_cnt_d = fetch_cnt_q + 16'd1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) fetch_cnt_q <= 16'h0000;
      else       fetch_cnt_q <= fetch_cnt_d;
   end

   assign bus.fetch_count = fetch_cnt_q;
`else
   assign bus.fetch_count = 16'h0000;
`endif

   assign bus.imem_addr   = pc_q;
   assign bus.instruction = instr_q;
   assign bus.instr_valid = valid_q;
   assign bus.pc_out      = pc_out_q;
   assign bus.halted      = halted_q;

endmodule
